// File: rtl/fc_pkg.sv
// ----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the FC processing-element driver:
//   - FSM state encoding
//   - datapath widths (int8 activations/weights, int32 accumulator)
//   - int8 saturation bounds, expressed in the 34-bit requant domain
//   - helper for the round-half-up bias used by the requantizer
// ----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUT    = 2'd3
    } fc_state_e;

    localparam int ACT_W = 8;
    localparam int ACC_W = 32;
    localparam int SH_W  = 5;
    // Two guard bits so that acc + rounding bias can never wrap
    localparam int RQ_W  = ACC_W + 2;

    localparam logic signed [ACT_W-1:0] INT8_MAX = 8'sh7F;
    localparam logic signed [ACT_W-1:0] INT8_MIN = 8'sh80;

    localparam logic signed [RQ_W-1:0] RQ_MAX = 34'sh0_0000_007F;
    localparam logic signed [RQ_W-1:0] RQ_MIN = 34'sh3_FFFF_FF80;

    // Rounding bias added before the arithmetic right shift: half an LSB
    // of the result, or nothing when no shift is applied.
    function automatic logic signed [RQ_W-1:0] round_bias(input logic [SH_W-1:0] sh);
        logic signed [RQ_W-1:0] one;
        one = 34'sd1;
        if (sh == 5'd0) begin
            return 34'sd0;
        end else begin
            return one << (sh - 5'd1);
        end
    endfunction

endpackage

// File: rtl/fc_requant.sv
// ----------------------------------------------------------------------------
// fc_requant
// Combinational int32 -> int8 requantizer:
//   t = (acc + round_bias(shift)) >>> shift, optional ReLU, saturate to int8.
// Ports:
//   i_acc      in  32  signed accumulator value
//   i_shift    in  5   arithmetic right-shift amount
//   i_relu_en  in  1   clamp negative results to zero
//   o_q        out 8   signed requantized result
// ----------------------------------------------------------------------------
module fc_requant
    import fc_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [SH_W-1:0]  i_shift,
    input  logic                    i_relu_en,
    output logic signed [ACT_W-1:0] o_q
);

    logic signed [RQ_W-1:0] w_ext;
    logic signed [RQ_W-1:0] w_sum;
    logic signed [RQ_W-1:0] w_shr;
    logic signed [RQ_W-1:0] w_relu;

    // Round, shift, ReLU and saturate in the widened signed domain
    always_comb begin
        w_ext = {{(RQ_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
        w_sum = w_ext + round_bias(i_shift);
        w_shr = w_sum >>> i_shift;

        if (i_relu_en && w_shr[RQ_W-1]) begin
            w_relu = 34'sd0;
        end else begin
            w_relu = w_shr;
        end

        if (w_relu > RQ_MAX) begin
            o_q = INT8_MAX;
        end else if (w_relu < RQ_MIN) begin
            o_q = INT8_MIN;
        end else begin
            o_q = w_relu[ACT_W-1:0];
        end
    end

endmodule

// File: rtl/fc_pe_driver.sv
// ----------------------------------------------------------------------------
// fc_pe_driver
// Transmit side of the FC PE interface. Streams (ifmap, weight) int8 pairs
// into a single FC PE whose output_sum is looped back as partial_sum, so the
// PE behaves as a MAC seeded with the job bias. The final int32 sum is
// captured, requantized to int8 and offered on a valid/ready output.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, vec_len, bias,
//   shift, relu_en                 job start pulse and config (IDLE only)
//   busy                           high whenever not IDLE
//   in_valid/in_ready/in_ifmap/
//   in_weight                      pair stream
//   pe_ifmap/pe_weight             registered PE operands (0 when idle)
//   pe_write_kernel                high in STREAM and DRAIN
//   pe_partial_sum/pe_output_sum   PE accumulation loop
//   out_valid/out_ready/out_data/
//   out_acc                        requantized result and raw sum
// ----------------------------------------------------------------------------
module fc_pe_driver
    import fc_pkg::*;
#(
    parameter int PE_LAT = 3,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACT_W-1:0] in_ifmap,
    input  logic signed [ACT_W-1:0] in_weight,
    output logic signed [ACT_W-1:0] pe_ifmap,
    output logic signed [ACT_W-1:0] pe_weight,
    output logic                    pe_write_kernel,
    output logic signed [ACC_W-1:0] pe_partial_sum,
    input  logic signed [ACC_W-1:0] pe_output_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACT_W-1:0] out_data,
    output logic signed [ACC_W-1:0] out_acc
);

    localparam int DR_W = $clog2(PE_LAT + 1);

    fc_state_e               r_state;
    logic [LEN_W-1:0]        r_vec_len;
    logic [LEN_W-1:0]        r_cnt;
    logic [DR_W-1:0]         r_drain_cnt;
    logic signed [ACC_W-1:0] r_bias;
    logic [SH_W-1:0]         r_shift;
    logic                    r_relu_en;

    logic                    r_busy;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_pe_write_kernel;
    logic signed [ACT_W-1:0] r_pe_ifmap;
    logic signed [ACT_W-1:0] r_pe_weight;
    logic signed [ACT_W-1:0] r_out_data;
    logic signed [ACC_W-1:0] r_out_acc;

    // r_first_drv is high in the cycle the first product of the job sits on
    // the PE inputs; the pipe delays it to the cycle the PE samples
    // partial_sum for that product.
    logic                    r_first_drv;
    logic [PE_LAT-2:0]       r_first_pipe;

    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_first_dly;
    logic signed [ACC_W-1:0] w_rq_acc;
    logic [SH_W-1:0]         w_rq_shift;
    logic                    w_rq_relu;
    logic signed [ACT_W-1:0] w_rq_q;

    assign w_in_hs     = in_valid & r_in_ready;
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_first_dly = r_first_pipe[PE_LAT-2];

    // Seed the loop with bias for the first product, otherwise feed back
    assign pe_partial_sum = w_first_dly ? r_bias : pe_output_sum;

    assign busy            = r_busy;
    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign pe_write_kernel = r_pe_write_kernel;
    assign pe_ifmap        = r_pe_ifmap;
    assign pe_weight       = r_pe_weight;
    assign out_data        = r_out_data;
    assign out_acc         = r_out_acc;

    // Requant source: the raw bias for an empty job started from IDLE,
    // otherwise the PE sum with the latched job config
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_rq_acc   = bias;
            w_rq_shift = shift;
            w_rq_relu  = relu_en;
        end else begin
            w_rq_acc   = pe_output_sum;
            w_rq_shift = r_shift;
            w_rq_relu  = r_relu_en;
        end
    end

    fc_requant u_requant (
        .i_acc     (w_rq_acc),
        .i_shift   (w_rq_shift),
        .i_relu_en (w_rq_relu),
        .o_q       (w_rq_q)
    );

    // Delay line aligning the first-pair flag with the PE partial_sum sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_pipe <= '0;
        end else begin
            r_first_pipe[0] <= r_first_drv;
            for (int i = 1; i < PE_LAT - 1; i++) begin
                r_first_pipe[i] <= r_first_pipe[i-1];
            end
        end
    end

    // Job FSM with registered handshake, PE operand and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_vec_len         <= '0;
            r_cnt             <= '0;
            r_drain_cnt       <= '0;
            r_bias            <= 32'sd0;
            r_shift           <= 5'd0;
            r_relu_en         <= 1'b0;
            r_busy            <= 1'b0;
            r_in_ready        <= 1'b0;
            r_out_valid       <= 1'b0;
            r_pe_write_kernel <= 1'b0;
            r_pe_ifmap        <= 8'sd0;
            r_pe_weight       <= 8'sd0;
            r_out_data        <= 8'sd0;
            r_out_acc         <= 32'sd0;
            r_first_drv       <= 1'b0;
        end else begin
            // Idle PE cycles accumulate a zero product
            r_pe_ifmap  <= 8'sd0;
            r_pe_weight <= 8'sd0;
            r_first_drv <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec_len <= vec_len;
                        r_bias    <= bias;
                        r_shift   <= shift;
                        r_relu_en <= relu_en;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (vec_len != '0) begin
                            r_in_ready        <= 1'b1;
                            r_pe_write_kernel <= 1'b1;
                            r_state           <= ST_STREAM;
                        end else begin
                            // Empty job: the result is the requantized bias
                            r_out_acc   <= bias;
                            r_out_data  <= w_rq_q;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_STREAM: begin
                    if (w_in_hs) begin
                        r_pe_ifmap  <= in_ifmap;
                        r_pe_weight <= in_weight;
                        r_first_drv <= (r_cnt == '0);
                        r_cnt       <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
                        if ((r_cnt + {{(LEN_W-1){1'b0}}, 1'b1}) == r_vec_len) begin
                            r_in_ready  <= 1'b0;
                            r_drain_cnt <= '0;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end

                ST_DRAIN: begin
                    // Last product is on the PE inputs in the first DRAIN
                    // cycle and reaches output_sum PE_LAT cycles later
                    if (r_drain_cnt == DR_W'(PE_LAT)) begin
                        r_out_acc         <= pe_output_sum;
                        r_out_data        <= w_rq_q;
                        r_out_valid       <= 1'b1;
                        r_pe_write_kernel <= 1'b0;
                        r_state           <= ST_OUT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + {{(DR_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_OUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_OUT;
                    end
                end

                default: begin
                    r_state           <= ST_IDLE;
                    r_busy            <= 1'b0;
                    r_in_ready        <= 1'b0;
                    r_out_valid       <= 1'b0;
                    r_pe_write_kernel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_pe_driver.sv
// ----------------------------------------------------------------------------
// tb_fc_pe_driver
// Bench for fc_pe_driver with a behavioural 3-stage FC PE closing the
// output_sum -> partial_sum loop. Expected results are computed from the
// job description and queued when a job is driven, then popped and compared
// when the driver presents its result.
// ----------------------------------------------------------------------------
module tb_fc_pe_driver;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [15:0]        vec_len = 16'd0;
    logic signed [31:0] bias = 32'sd0;
    logic [4:0]         shift = 5'd0;
    logic               relu_en = 1'b0;
    logic               busy;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [7:0]  in_ifmap = 8'sd0;
    logic signed [7:0]  in_weight = 8'sd0;
    logic signed [7:0]  pe_ifmap;
    logic signed [7:0]  pe_weight;
    logic               pe_write_kernel;
    logic signed [31:0] pe_partial_sum;
    logic signed [31:0] pe_output_sum;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [7:0]  out_data;
    logic signed [31:0] out_acc;

    int checks = 0;
    int errors = 0;

    longint sb_acc[$];
    longint sb_data[$];
    int     pa[$];
    int     pw[$];

    always #5 clk = ~clk;

    fc_pe_driver #(.PE_LAT(3), .LEN_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vec_len         (vec_len),
        .bias            (bias),
        .shift           (shift),
        .relu_en         (relu_en),
        .busy            (busy),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_ifmap        (in_ifmap),
        .in_weight       (in_weight),
        .pe_ifmap        (pe_ifmap),
        .pe_weight       (pe_weight),
        .pe_write_kernel (pe_write_kernel),
        .pe_partial_sum  (pe_partial_sum),
        .pe_output_sum   (pe_output_sum),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_acc         (out_acc)
    );

    // Behavioural FC PE: product of the operands driven in cycle d is added
    // to partial_sum sampled in cycle d+2 and appears on output_sum in d+3.
    logic signed [15:0] pe_p1 = 16'sd0;
    logic signed [15:0] pe_p2 = 16'sd0;
    logic signed [31:0] pe_sum = 32'sd0;
    logic signed [63:0] pe_wide;

    assign pe_wide       = $signed(pe_partial_sum) + pe_p2;
    assign pe_output_sum = pe_sum;

    always @(posedge clk) begin
        pe_p1 <= pe_ifmap * pe_weight;
        pe_p2 <= pe_p1;
        if (pe_wide > 64'sd2147483647)
            pe_sum <= 32'sh7FFFFFFF;
        else if (pe_wide < -64'sd2147483648)
            pe_sum <= 32'sh80000000;
        else
            pe_sum <= pe_wide[31:0];
    end

    function automatic longint rq_model(input longint acc, input int sh, input bit relu);
        longint t;
        t = acc;
        if (sh > 0) t = t + (longint'(1) << (sh - 1));
        t = t >>> sh;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        else if (t < -128) t = -128;
        return t;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len, input int b, input int sh, input bit relu);
        start   = 1'b1;
        vec_len = 16'(len);
        bias    = 32'(b);
        shift   = 5'(sh);
        relu_en = relu;
        tick();
        start   = 1'b0;
    endtask

    // Offer one pair until accepted; fails the check if never accepted
    task automatic send_pair(input string tag, input int a, input int w);
        bit hs;
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_ifmap  = 8'(a);
        in_weight = 8'(w);
        for (int k = 0; k < 50; k++) begin
            hs = in_ready;
            tick();
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check({tag, " pair_accept"}, 64'sd0, 64'sd1);
    endtask

    // Drive a full job from pa/pw; exp_wait < 0 skips the latency check
    task automatic run_job(input string tag, input int len, input int b, input int sh,
                           input bit relu, input int gap, input int exp_wait);
        longint acc;
        int     n;
        acc = b;
        for (int i = 0; i < len; i++) acc = acc + pa[i] * pw[i];
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        sb_acc.push_back(acc);
        sb_data.push_back(rq_model(acc, sh, relu));

        pulse_start(len, b, sh, relu);
        check({tag, " busy"}, busy, 1);
        for (int i = 0; i < len; i++) begin
            send_pair(tag, pa[i], pw[i]);
            if (i < len - 1) repeat (gap) tick();
        end
        if (len > 0) check({tag, " in_ready_drop"}, in_ready, 0);

        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (exp_wait >= 0) check({tag, " latency"}, n, exp_wait);
        else check({tag, " out_valid"}, out_valid, 1);
    endtask

    task automatic collect(input string tag);
        longint ea;
        longint ed;
        if (sb_acc.size() == 0) begin
            check({tag, " sb_nonempty"}, 0, 1);
        end else begin
            ea = sb_acc.pop_front();
            ed = sb_data.pop_front();
            check({tag, " out_acc"}, out_acc, ea);
            check({tag, " out_data"}, out_data, ed);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid_drop"}, out_valid, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst write_kernel", pe_write_kernel, 0);
        check("rst pe_ifmap", pe_ifmap, 0);
        check("rst out_acc", out_acc, 0);
        rst = 1'b0;
        tick();

        // Back-to-back pairs: result visible 4 edges after the last accept
        pa = '{2, -4, 7};
        pw = '{3, 5, 1};
        run_job("b2b", 3, 0, 0, 1'b0, 0, 4);
        check("b2b write_kernel_off", pe_write_kernel, 0);
        collect("b2b");

        // Same job with two idle cycles between pairs
        run_job("gap", 3, 0, 0, 1'b0, 2, 4);
        collect("gap");

        // Bias plus rounding shift
        pa = '{10};
        pw = '{10};
        run_job("shift3", 1, 100, 3, 1'b0, 0, 4);
        collect("shift3");

        // Positive saturation
        pa = '{127, 127};
        pw = '{127, 127};
        run_job("sat_pos", 2, 0, 0, 1'b0, 0, 4);
        collect("sat_pos");

        // Negative saturation, then the same with ReLU
        pa = '{-128};
        pw = '{127};
        run_job("sat_neg", 1, 0, 0, 1'b0, 0, 4);
        collect("sat_neg");
        run_job("relu", 1, 0, 0, 1'b1, 0, 4);
        collect("relu");

        // Back-pressure: result held, start ignored while in OUT
        pa = '{-100, 3};
        pw = '{50, 7};
        run_job("bp", 2, 17, 2, 1'b0, 0, 4);
        for (int c = 0; c < 5; c++) begin
            start   = (c == 2);
            vec_len = 16'd5;
            tick();
        end
        start = 1'b0;
        check("bp hold_valid", out_valid, 1);
        check("bp hold_acc", out_acc, 17 - 5000 + 21);
        check("bp hold_data", out_data, rq_model(17 - 5000 + 21, 2, 1'b0));
        collect("bp");
        check("bp no_restart", in_ready, 0);
        pa = '{1};
        pw = '{1};
        run_job("after_bp", 1, 0, 0, 1'b0, 0, 4);
        collect("after_bp");

        // Reset mid-STREAM aborts the job with no result
        pulse_start(3, 55, 0, 1'b0);
        send_pair("abort", 9, 9);
        rst = 1'b1;
        tick();
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 0);
        check("abort out_valid", out_valid, 0);
        check("abort write_kernel", pe_write_kernel, 0);
        check("abort pe_ifmap", pe_ifmap, 0);
        check("abort pe_weight", pe_weight, 0);
        check("abort out_data", out_data, 0);
        check("abort out_acc", out_acc, 0);
        rst = 1'b0;
        repeat (8) tick();
        check("abort no_result", out_valid, 0);

        // Empty job: requantized bias, no pair consumed
        in_valid = 1'b1;
        run_job("len0", 0, -300, 0, 1'b0, 0, 0);
        check("len0 no_accept", in_ready, 0);
        in_valid = 1'b0;
        collect("len0");

        check("sb drained", sb_acc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
